// File: rtl/sort_engine_pkg.sv
// Shared types and helpers for the odd-even transposition sort engine.
package sort_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} sort_state_t;

  // Phase counter must hold 0..n-1 plus headroom for the exit compare.
  function automatic int phase_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Load/result handshake bundle for sort_engine; lane i of DIN/DOUT_VEC at [i*DATA_WIDTH +: DATA_WIDTH].
interface sort_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                             IN_VALID;
  logic                             IN_READY;
  logic [DATA_WIDTH*NUM_INPUTS-1:0] DIN;
  logic                             SIGNED_MODE;
  logic                             DESCEND;
  logic                             OUT_VALID;
  logic                             OUT_READY;
  logic [DATA_WIDTH*NUM_INPUTS-1:0] DOUT_VEC;
  logic [DATA_WIDTH-1:0]            MIN_OUT;
  logic [DATA_WIDTH-1:0]            MAX_OUT;
  logic [IDX_W-1:0]                 RANK;
  logic [DATA_WIDTH-1:0]            DOUT_RANK;

  modport master (
    output IN_VALID, DIN, SIGNED_MODE, DESCEND, OUT_READY, RANK,
    input  IN_READY, OUT_VALID, DOUT_VEC, MIN_OUT, MAX_OUT, DOUT_RANK
  );

  modport slave (
    input  IN_VALID, DIN, SIGNED_MODE, DESCEND, OUT_READY, RANK,
    output IN_READY, OUT_VALID, DOUT_VEC, MIN_OUT, MAX_OUT, DOUT_RANK
  );

endinterface

// File: rtl/sort_engine_cmp_swap.sv
// Compare-exchange cell: orders one adjacent lane pair, swapping only when strictly out of order.
module cmp_swap #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  input  logic                  descend,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  swapped
);

  logic a_gt_b, a_lt_b;

  always_comb begin
    if (is_signed) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
    // Strict compare keeps equal values in place, so the sort is stable.
    swapped = descend ? a_lt_b : a_gt_b;
    lo      = swapped ? b : a;
    hi      = swapped ? a : b;
  end

endmodule

// File: rtl/sort_engine.sv
// Multi-cycle odd-even transposition sorter: one phase per clock, early exit after two clean phases.
module sort_engine
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8
) (
  input logic          CLK,
  input logic          RST_N,
  sort_engine_if.slave bus
);

  localparam int NE   = NUM_INPUTS / 2;
  localparam int NO   = (NUM_INPUTS - 1) / 2;
  localparam int NO_A = (NO > 0) ? NO : 1;
  localparam int PW   = phase_w(NUM_INPUTS);
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_INPUTS - 1);

  typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lanes_t;

  sort_state_t   state_q, state_d;
  logic [PW-1:0] phase_q;
  logic          noswap_prev_q;
  lanes_t        lanes_q;
  logic          sgn_q, desc_q;

  lanes_t        even_lanes, odd_lanes, next_lanes;
  logic [NE-1:0][DATA_WIDTH-1:0]   e_lo, e_hi;
  logic [NE-1:0]                   e_sw;
  logic [NO_A-1:0][DATA_WIDTH-1:0] o_lo, o_hi;
  logic [NO_A-1:0]                 o_sw;
  logic          any_swap, sort_exit;
  logic          in_ready, out_valid;

  // Even bank pairs (0,1),(2,3),...
  for (genvar g = 0; g < NE; g++) begin : g_even
    cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cs (
      .a(lanes_q[2*g]), .b(lanes_q[2*g+1]), .is_signed(sgn_q), .descend(desc_q),
      .lo(e_lo[g]), .hi(e_hi[g]), .swapped(e_sw[g])
    );
  end

  // Odd bank pairs (1,2),(3,4),...; absent when only two lanes exist.
  if (NO > 0) begin : g_odd_bank
    for (genvar g = 0; g < NO; g++) begin : g_odd
      cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cs (
        .a(lanes_q[2*g+1]), .b(lanes_q[2*g+2]), .is_signed(sgn_q), .descend(desc_q),
        .lo(o_lo[g]), .hi(o_hi[g]), .swapped(o_sw[g])
      );
    end
  end else begin : g_no_odd
    assign o_lo = '0;
    assign o_hi = '0;
    assign o_sw = '0;
  end

  always_comb begin
    even_lanes = lanes_q;
    odd_lanes  = lanes_q;
    for (int i = 0; i < NE; i++) begin
      even_lanes[2*i]   = e_lo[i];
      even_lanes[2*i+1] = e_hi[i];
    end
    for (int i = 0; i < NO; i++) begin
      odd_lanes[2*i+1] = o_lo[i];
      odd_lanes[2*i+2] = o_hi[i];
    end
  end

  assign any_swap   = phase_q[0] ? |o_sw : |e_sw;
  assign next_lanes = phase_q[0] ? odd_lanes : even_lanes;
  // Two consecutive swap-free phases (one even, one odd) prove the vector is sorted.
  assign sort_exit  = (phase_q == LAST_PH) || (!any_swap && noswap_prev_q);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.IN_VALID)  state_d = S_SORT;
      S_SORT:  if (sort_exit)     state_d = S_DONE;
      S_DONE:  if (bus.OUT_READY) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lanes_q       <= '0;
      sgn_q         <= 1'b0;
      desc_q        <= 1'b0;
      phase_q       <= '0;
      noswap_prev_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.IN_VALID) begin
          lanes_q       <= bus.DIN;
          sgn_q         <= bus.SIGNED_MODE;
          desc_q        <= bus.DESCEND;
          phase_q       <= '0;
          noswap_prev_q <= 1'b0;
        end
        S_SORT: begin
          lanes_q <= next_lanes;
          if (!sort_exit) begin
            phase_q       <= phase_q + 1'b1;
            noswap_prev_q <= !any_swap;
          end
        end
        default: ;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] rank_sel;

  always_comb begin
    rank_sel = '0;
    if (out_valid && (int'(bus.RANK) < NUM_INPUTS)) rank_sel = lanes_q[bus.RANK];
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid;
  assign bus.DOUT_VEC  = out_valid ? lanes_q : '0;
  assign bus.MIN_OUT   = out_valid ? (desc_q ? lanes_q[NUM_INPUTS-1] : lanes_q[0]) : '0;
  assign bus.MAX_OUT   = out_valid ? (desc_q ? lanes_q[0] : lanes_q[NUM_INPUTS-1]) : '0;
  assign bus.DOUT_RANK = rank_sel;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: 4-lane vector table, hold/reset sequences, and a 5-lane instance.
module tb_sort_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_engine_if #(.DATA_WIDTH(8), .NUM_INPUTS(4)) a_if ();
  sort_engine_if #(.DATA_WIDTH(8), .NUM_INPUTS(5)) b_if ();

  sort_engine #(.DATA_WIDTH(8), .NUM_INPUTS(4)) u_a (.CLK(clk), .RST_N(rst_n), .bus(a_if));
  sort_engine #(.DATA_WIDTH(8), .NUM_INPUTS(5)) u_b (.CLK(clk), .RST_N(rst_n), .bus(b_if));

  typedef struct {
    string       name;
    logic [31:0] din;
    bit          sgn;
    bit          desc;
    logic [1:0]  rank;
    logic [31:0] exp;
    logic [7:0]  emin;
    logic [7:0]  emax;
    logic [7:0]  erank;
    int          lat;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vt[10];

  function automatic logic [31:0] pk4(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] din, input bit sgn, desc,
                              input logic [1:0] rank, input logic [31:0] exp,
                              input logic [7:0] emin, emax, erank, input int lat);
    vec_t v;
    v.name = nm; v.din = din; v.sgn = sgn; v.desc = desc; v.rank = rank; v.exp = exp;
    v.emin = emin; v.emax = emax; v.erank = erank; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Precondition: called at a negedge with DUT A idle; returns just after the accept edge.
  task automatic load_a(input vec_t v);
    a_if.DIN = v.din;
    a_if.SIGNED_MODE = v.sgn;
    a_if.DESCEND = v.desc;
    a_if.RANK = v.rank;
    a_if.IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    a_if.IN_VALID = 1'b0;
    a_if.DIN = 32'hA5C3_5A3C;
  endtask

  // Counts accept-relative edges until OUT_VALID is seen; bounded so a stuck FSM still reports.
  task automatic wait_done_a(output int n);
    n = 0;
    @(negedge clk);
    while (a_if.OUT_VALID !== 1'b1 && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
    end
  endtask

  task automatic retire_a(input string nm);
    a_if.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    a_if.OUT_READY = 1'b0;
    @(negedge clk);
    check({nm, ".ret_rdy"}, 64'(a_if.IN_READY), 64'd1);
    check({nm, ".ret_vld"}, 64'(a_if.OUT_VALID), 64'd0);
  endtask

  task automatic xact_a(input vec_t v);
    int n;
    load_a(v);
    wait_done_a(n);
    check({v.name, ".lat"},  64'(n), 64'(v.lat));
    check({v.name, ".vec"},  64'(a_if.DOUT_VEC), 64'(v.exp));
    check({v.name, ".min"},  64'(a_if.MIN_OUT), 64'(v.emin));
    check({v.name, ".max"},  64'(a_if.MAX_OUT), 64'(v.emax));
    check({v.name, ".rank"}, 64'(a_if.DOUT_RANK), 64'(v.erank));
    retire_a(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_if.IN_VALID = 0; a_if.DIN = '0; a_if.SIGNED_MODE = 0; a_if.DESCEND = 0;
    a_if.OUT_READY = 0; a_if.RANK = '0;
    b_if.IN_VALID = 0; b_if.DIN = '0; b_if.SIGNED_MODE = 0; b_if.DESCEND = 0;
    b_if.OUT_READY = 0; b_if.RANK = '0;

    vt[0] = mk("basic",    pk4(45, 3, 29, 88),           0, 0, 2, pk4(3, 29, 45, 88),           3,     88,    45,    4);
    vt[1] = mk("s_asc",    pk4(8'h80, 8'h7F, 8'h01, 8'hFF), 1, 0, 1, pk4(8'h80, 8'hFF, 8'h01, 8'h7F), 8'h80, 8'h7F, 8'hFF, 4);
    vt[2] = mk("u_asc",    pk4(8'h80, 8'h7F, 8'h01, 8'hFF), 0, 0, 3, pk4(8'h01, 8'h7F, 8'h80, 8'hFF), 8'h01, 8'hFF, 8'hFF, 4);
    vt[3] = mk("s_desc",   pk4(8'h80, 8'h7F, 8'h01, 8'hFF), 1, 1, 0, pk4(8'h7F, 8'h01, 8'hFF, 8'h80), 8'h80, 8'h7F, 8'h7F, 4);
    vt[4] = mk("u_desc",   pk4(8'h80, 8'h7F, 8'h01, 8'hFF), 0, 1, 2, pk4(8'hFF, 8'h80, 8'h7F, 8'h01), 8'h01, 8'hFF, 8'h7F, 4);
    vt[5] = mk("presort",  pk4(1, 2, 3, 4),              0, 0, 3, pk4(1, 2, 3, 4),              1,     4,     4,     2);
    vt[6] = mk("dups",     pk4(5, 5, 5, 5),              1, 0, 0, pk4(5, 5, 5, 5),              5,     5,     5,     2);
    vt[7] = mk("early3",   pk4(2, 1, 3, 4),              0, 0, 1, pk4(1, 2, 3, 4),              1,     4,     2,     3);
    vt[8] = mk("pre_desc", pk4(4, 3, 2, 1),              0, 1, 2, pk4(4, 3, 2, 1),              1,     4,     2,     2);
    vt[9] = mk("rev_desc", pk4(1, 2, 3, 4),              0, 1, 1, pk4(4, 3, 2, 1),              1,     4,     3,     4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready",  64'(a_if.IN_READY), 64'd1);
    check("rst.out_valid", 64'(a_if.OUT_VALID), 64'd0);
    check("rst.vec",       64'(a_if.DOUT_VEC), 64'd0);
    check("rst.min",       64'(a_if.MIN_OUT), 64'd0);
    check("rst.max",       64'(a_if.MAX_OUT), 64'd0);
    check("rst.rank",      64'(a_if.DOUT_RANK), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) xact_a(vt[i]);

    // Backpressure: result holds while new loads are offered and ignored.
    load_a(vt[0]);
    wait_done_a(n);
    check("hold.lat", 64'(n), 64'd4);
    a_if.IN_VALID = 1'b1;
    a_if.DIN = pk4(9, 9, 9, 9);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      check("hold.vld", 64'(a_if.OUT_VALID), 64'd1);
      check("hold.rdy", 64'(a_if.IN_READY), 64'd0);
      check("hold.vec", 64'(a_if.DOUT_VEC), 64'(vt[0].exp));
    end
    a_if.DIN = vt[5].din; a_if.SIGNED_MODE = 0; a_if.DESCEND = 0; a_if.RANK = 2'd3;
    a_if.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    a_if.OUT_READY = 1'b0;
    @(negedge clk);
    check("hold.rel_rdy", 64'(a_if.IN_READY), 64'd1);
    check("hold.rel_vld", 64'(a_if.OUT_VALID), 64'd0);
    check("hold.rel_vec", 64'(a_if.DOUT_VEC), 64'd0);
    @(posedge clk);
    #1;
    a_if.IN_VALID = 1'b0;
    wait_done_a(n);
    check("reload.lat", 64'(n), 64'd2);
    check("reload.vec", 64'(a_if.DOUT_VEC), 64'(vt[5].exp));
    retire_a("reload");

    // Reset while SORT is on phase 1 aborts the sort.
    load_a(vt[0]);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.rdy", 64'(a_if.IN_READY), 64'd1);
    check("abort.vld", 64'(a_if.OUT_VALID), 64'd0);
    check("abort.vec", 64'(a_if.DOUT_VEC), 64'd0);
    check("abort.max", 64'(a_if.MAX_OUT), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      check("abort.stay_vld", 64'(a_if.OUT_VALID), 64'd0);
    end
    check("abort.stay_rdy", 64'(a_if.IN_READY), 64'd1);
    xact_a(vt[1]);

    // Five lanes: odd lane count, full-length sort, out-of-range rank.
    b_if.DIN = {8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
    b_if.RANK = 3'd7;
    b_if.IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    b_if.IN_VALID = 1'b0;
    n = 0;
    @(negedge clk);
    while (b_if.OUT_VALID !== 1'b1 && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("n5.lat",   64'(n), 64'd5);
    check("n5.vec",   64'(b_if.DOUT_VEC), 64'({8'd9, 8'd7, 8'd5, 8'd3, 8'd1}));
    check("n5.min",   64'(b_if.MIN_OUT), 64'd1);
    check("n5.max",   64'(b_if.MAX_OUT), 64'd9);
    check("n5.rank7", 64'(b_if.DOUT_RANK), 64'd0);
    b_if.RANK = 3'd4;
    #1;
    check("n5.rank4", 64'(b_if.DOUT_RANK), 64'd9);
    b_if.RANK = 3'd1;
    #1;
    check("n5.rank1", 64'(b_if.DOUT_RANK), 64'd3);
    b_if.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    b_if.OUT_READY = 1'b0;
    @(negedge clk);
    check("n5.ret_rdy", 64'(b_if.IN_READY), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
